// File: rtl/free_list_ctrl.sv
// Physical-register free list for the rename stage.
// A circular FIFO of unmapped physical tags. Up to two tags are handed to the
// RAT per cycle (INT slot, LS slot). Up to two tags come back from the ROB.
// The dispatch pair is granted all-or-nothing, so the two slots stay in order.
module free_list_ctrl #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int DEPTH     = 32,
  localparam int TAG_W    = $clog2(PHYS_REGS),
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             req_int_rat2fl,
  input  logic             req_ls_rat2fl,
  output logic [TAG_W-1:0] tag_int_fl2rat,
  output logic [TAG_W-1:0] tag_ls_fl2rat,
  output logic             grant_fl2rat,
  output logic             stall_fl2id,
  input  logic             free0_valid_rob2fl,
  input  logic [TAG_W-1:0] free0_tag_rob2fl,
  input  logic             free1_valid_rob2fl,
  input  logic [TAG_W-1:0] free1_tag_rob2fl,
  output logic [CNT_W-1:0] count_fl,
  output logic             overflow_err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [1:0]       n_req;
  logic [1:0]       n_alloc;
  logic             grant;
  logic             f0_ok, f1_ok;
  logic             acc0, acc1;
  logic [1:0]       n_acc;
  logic [CNT_W-1:0] count_after_alloc;
  logic [CNT_W-1:0] space;
  logic [CNT_W-1:0] space_after0;
  logic             drop;

  // Tag offer and all-or-nothing grant, straight from the current head.
  always_comb begin
    head_p1        = head_q + PTR_W'(1);
    n_req          = {1'b0, req_int_rat2fl} + {1'b0, req_ls_rat2fl};
    grant          = (count_q >= CNT_W'(n_req));
    n_alloc        = grant ? n_req : 2'd0;
    tag_int_fl2rat = mem_q[head_q];
    tag_ls_fl2rat  = req_int_rat2fl ? mem_q[head_p1] : mem_q[head_q];
    grant_fl2rat   = grant;
    stall_fl2id    = (n_req != 2'd0) && !grant;
  end

  // Free acceptance. Space is measured after this cycle's allocation, and
  // free0 has priority over free1 for the last slot. Tag 0 is never recycled.
  always_comb begin
    tail_p1           = tail_q + PTR_W'(1);
    f0_ok             = free0_valid_rob2fl && (free0_tag_rob2fl != '0);
    f1_ok             = free1_valid_rob2fl && (free1_tag_rob2fl != '0);
    count_after_alloc = count_q - CNT_W'(n_alloc);
    space             = DEPTH_C - count_after_alloc;
    acc0              = f0_ok && (space != '0);
    space_after0      = space - CNT_W'(acc0);
    acc1              = f1_ok && (space_after0 != '0);
    n_acc             = {1'b0, acc0} + {1'b0, acc1};
    drop              = (f0_ok && !acc0) || (f1_ok && !acc1);
  end

  // Next-state: storage writes at tail, pointer and count updates.
  // Freed tags land in storage only at the edge, so there is no bypass
  // from a same-cycle free to the offer.
  always_comb begin
    mem_d = mem_q;
    if (acc0) begin
      mem_d[tail_q] = free0_tag_rob2fl;
    end
    if (acc1) begin
      if (acc0) begin
        mem_d[tail_p1] = free1_tag_rob2fl;
      end else begin
        mem_d[tail_q] = free1_tag_rob2fl;
      end
    end
    head_d  = head_q + PTR_W'(n_alloc);
    tail_d  = tail_q + PTR_W'(n_acc);
    count_d = count_after_alloc + CNT_W'(n_acc);
    ovf_d   = ovf_q || drop;
  end

  // State registers; reset loads the unmapped tags ARCH_REGS.. in order.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TAG_W'(ARCH_REGS + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= DEPTH_C;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_fl     = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: doc/free_list_ctrl.md
Name: free_list_ctrl

Overview:
Physical-register free-list manager feeding the rename stage.
- Holds the tags of the physical registers that are not currently mapped: 64 physical, 32 architectural.
- Serves up to two destination allocations per cycle, one for the INT slot and one for the LS slot, to the RAT.
- Accepts up to two released tags per cycle from the ROB (freeMeUp).
- Stalls the dual-issue dispatch pair as a unit when tags run short.

Parameters:
PHYS_REGS, 64, number of physical registers; tag width is log2(PHYS_REGS) = 6.
ARCH_REGS, 32, number of architectural registers; tags 0..ARCH_REGS-1 are mapped at reset.
DEPTH, 32, free-list capacity, equal to PHYS_REGS-ARCH_REGS.

Ports:
clk  in  1  clock, rising edge.
res_n  in  1  asynchronous active-low reset.
req_int_rat2fl  in  1  INT slot needs a destination tag this cycle.
req_ls_rat2fl  in  1  LS slot needs a destination tag this cycle; low for stores and for rd=R0.
tag_int_fl2rat  out  6  tag offered to the INT slot.
tag_ls_fl2rat  out  6  tag offered to the LS slot.
grant_fl2rat  out  1  all asserted requests are served this cycle.
stall_fl2id  out  1  at least one request is asserted and grant is low.
free0_valid_rob2fl  in  1  free0 tag valid.
free0_tag_rob2fl  in  6  first released tag.
free1_valid_rob2fl  in  1  free1 tag valid.
free1_tag_rob2fl  in  6  second released tag.
count_fl  out  6  number of free tags, 0..DEPTH.
overflow_err  out  1  sticky: a free was attempted while the list was full.

Behaviour:
- Storage: circular FIFO of DEPTH 6-bit entries.
  - 5-bit head and tail pointers wrap modulo DEPTH.
  - 6-bit count.
- Reset (async, res_n=0):
  - entry i = ARCH_REGS+i (tags 32..63); head=0, tail=0, count=32.
  - overflow_err=0.
  - Resulting outputs: tag_int=32, tag_ls=33, count_fl=32.
  - Reset mid-operation discards all in-flight state immediately.
- Tag offer, combinational from the current head:
  - If req_int=1: tag_int = entry[head] and tag_ls = entry[head+1].
  - If req_int=0: tag_ls = entry[head].
  - tag_int always shows entry[head].
- Grant (combinational, same cycle): n_req = req_int + req_ls; grant = (count >= n_req).
  - Grant is all-or-nothing: with count=1 and both requests high, neither slot is served and stall=1. This keeps the dispatch pair in order.
  - With n_req=0: grant=1 and stall=0.
- On the clock edge with grant=1: head advances by n_req.
- Frees:
  - Each valid free whose tag is not 0 is written at tail; tail advances by 1.
  - When both are valid, free0 is written at tail and free1 at tail+1.
  - When only free1 is valid, it is written at tail.
  - Frees of tag 0 are ignored: R0's physical register is never recycled.
- No bypass: a tag freed in cycle N is offerable from cycle N+1 at the earliest. An alloc at count=0 concurrent with a free is not granted.
- Count update per edge: count_next = count + n_free_accepted - (grant ? n_req : 0). Simultaneous alloc and free are both applied.
- Overflow: if count + n_free_accepted would exceed DEPTH after the same-cycle allocation:
  - excess frees are dropped;
  - count saturates at DEPTH;
  - overflow_err is set and stays 1 until reset.
- Wrap-around: head+1 and tail+1 computations wrap from 31 to 0.

Test Plan:
1. Reset, then idle -> tag_int=32, tag_ls=33, count_fl=32, grant=1, stall=0, overflow_err=0.
2. Both requests for 3 cycles -> tags (32,33), (34,35), (36,37) offered in turn, each with grant=1; count_fl=26 after the third edge.
3. Drain to count=1, then both requests -> grant=0, stall=1, count unchanged. Drop req_ls -> grant=1, tag_int=63, count=0.
4. At count=0, req_int together with free0=40 -> grant=0 that cycle. Next cycle: tag_int=40, grant=1, and count returns to 0 after the edge.
5. Free tags 5 and 9 while count=31 with no request -> 5 is accepted, count=32; 9 is dropped and overflow_err=1. Free of tag 0 at any count -> no count change.
6. Wrap-around and reset:
   - Cycle 40 allocations and frees so that head and tail cross 31->0 -> FIFO order is preserved.
   - Assert res_n=0 mid-burst -> outputs return to their reset values asynchronously.
